apb4_arbiter_master: RTL
========================

APB4_ARBITER_MASTER -- requirements
Module: apb4_arbiter_master

Interface
REQ-001 The block SHALL provide parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL provide parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles before a transfer is aborted (1..255).
REQ-003 The block SHALL provide port pclk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL provide port prst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL provide port req_valid  input  NREQ  per-requester transfer request.
REQ-006 The block SHALL provide port req_addr  input  32*NREQ  per-requester address, slice i = bits [32i+31:32i].
REQ-007 The block SHALL provide port req_write  input  NREQ  per-requester direction, 1 = write.
REQ-008 The block SHALL provide port req_wdata  input  32*NREQ  per-requester write data.
REQ-009 The block SHALL provide port req_ready  output  NREQ  one-hot accept; a request is taken when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-010 The block SHALL provide port rsp_valid  output  NREQ  one-hot one-cycle completion pulse.
REQ-011 The block SHALL provide port rsp_rdata  output  32  read data for the completing requester; 0 for writes and aborts.
REQ-012 The block SHALL provide port rsp_err  output  1  valid with rsp_valid; 1 = timeout abort.
REQ-013 The block SHALL provide ports paddr (output, 32), psel (output, 1), penable (output, 1), pwrite (output, 1) and pwdata (output, 32) as the APB4 master address/control/data signals.
REQ-014 The block SHALL provide ports pready (input, 1) and prdata (input, 32) as the APB4 slave response signals.

Function
REQ-015 The state machine SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-016 In IDLE, req_ready SHALL be combinational and equal to the one-hot round-robin winner among req_valid; it SHALL be all zero in every other state.
REQ-017 Round-robin search SHALL start at index (last_grant+1) mod NREQ and wrap; last_grant resets to NREQ-1 so that requester 0 wins first.
REQ-018 On an accept edge, the block SHALL latch the winner index, address, direction and wdata, update last_grant, and move to SETUP.
REQ-019 In SETUP, psel SHALL be 1, penable 0 and paddr/pwrite/pwdata SHALL equal the latched values; SETUP lasts exactly one cycle, then ACCESS.
REQ-020 In ACCESS, psel and penable SHALL be 1 with address/control/data held stable.
REQ-021 ACCESS with pready=1 at an edge SHALL complete the transfer: capture prdata (reads) or 0 (writes), clear rsp_err, and go to RESP.
REQ-022 ACCESS with pready=0 SHALL increment a wait counter; if pready is still 0 when the counter reaches TIMEOUT, the transfer SHALL be aborted: rsp_rdata=0, rsp_err=1, go to RESP.
REQ-023 When pready=1 on the same edge as the timeout, the transfer SHALL complete normally (pready wins).
REQ-024 In RESP, rsp_valid[winner] SHALL be 1 for exactly one cycle, psel=penable=0, then return to IDLE.
REQ-025 Minimum transfer latency SHALL be accept edge + 3 cycles to rsp_valid (SETUP, ACCESS, RESP); back-to-back accepts SHALL be spaced at least 4 cycles apart.
REQ-026 paddr/pwrite/pwdata SHALL hold their last values in IDLE and RESP; psel and penable SHALL be 0 outside SETUP/ACCESS.
REQ-027 A requester dropping req_valid after acceptance SHALL NOT affect the transfer in flight.
REQ-028 The wait counter SHALL be 8 bits, cleared on entry to SETUP, and SHALL NOT wrap.

Reset
REQ-029 While prst=1, all outputs SHALL be 0, the state SHALL be IDLE, last_grant SHALL be NREQ-1 and the wait counter SHALL be 0, regardless of the clock.
REQ-030 Assertion of prst mid-transfer SHALL immediately deassert psel and penable; the aborted transfer SHALL produce no rsp_valid.
REQ-031 The first accept SHALL occur no earlier than the first rising edge after prst is deasserted.

Verification
REQ-032 Single write: req0 writes 0xDEADBEEF to 0x10 with pready tied 1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid[0] with rsp_err=0 at cycle 3.
REQ-033 Read with two waits: req2 reads 0x20, pready low for 2 ACCESS cycles, prdata=0x20 -> rsp_rdata=0x20 and rsp_valid[2] five cycles after accept.
REQ-034 Fairness: all four req_valid held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-035 Timeout: pready held 0 with TIMEOUT=16 -> rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles; pready=1 exactly on the 16th cycle -> normal completion.
REQ-036 Reset mid-ACCESS: prst pulsed during the ACCESS phase of a req1 read -> psel=0 asynchronously, no rsp_valid, and the next grant goes to requester 0.
REQ-037 Stability: in every ACCESS cycle, paddr, pwrite and pwdata SHALL equal their SETUP values, checked by assertion.

Source files
------------

// File: rtl/apb4_arbiter_master.sv
// Round-robin arbiter feeding a single APB4 master port.
// One transfer in flight at a time; ACCESS is aborted with rsp_err after TIMEOUT wait cycles.
module apb4_arbiter_master #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 pclk,
   input  logic                 prst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_addr,
   input  logic [NREQ-1:0]      req_write,
   input  logic [32*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic [31:0]          paddr,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [31:0]          pwdata,
   input  logic                 pready,
   input  logic [31:0]          prdata
);

   // state  | meaning
   // IDLE   | arbitrate; req_ready shows the round-robin winner
   // SETUP  | APB setup phase, psel=1 penable=0 (one cycle)
   // ACCESS | APB access phase, wait for pready or timeout
   // RESP   | one-cycle rsp_valid pulse to the winner

   localparam int              IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE     = NREQ'(1);
   localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [IW-1:0]     last_grant;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     sel_idx;
   logic              sel_found;
   logic [IW:0]       rr_start;
   logic [2*NREQ-1:0] rr_shift;
   logic [NREQ-1:0]   rr_rot;
   int                rr_pos;
   int                rr_sum;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_write;
   logic [7:0]        wait_cnt;
   logic              timeout_hit;

   // Rotate the request vector so the search always starts at bit 0,
   // then map the first set bit back to a requester index.
   always_comb begin
      rr_start  = {1'b0, last_grant} + (IW+1)'(1);
      rr_shift  = {req_valid, req_valid} >> rr_start;
      rr_rot    = rr_shift[NREQ-1:0];
      sel_found = |rr_rot;
      rr_pos    = 0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rr_rot[j]) rr_pos = j;
      end
      rr_sum = int'(rr_start) + rr_pos;
      if (rr_sum >= NREQ) rr_sum = rr_sum - NREQ;
      sel_idx = IW'(rr_sum);
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_idx == IW'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_write = req_write[i];
         end
      end
   end

   assign timeout_hit = (wait_cnt >= TO_LAST);

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_found) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         last_grant <= IW'(NREQ - 1);
         win_idx    <= '0;
         wait_cnt   <= '0;
         paddr      <= '0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  win_idx    <= sel_idx;
                  last_grant <= sel_idx;
                  paddr      <= sel_addr;
                  pwrite     <= sel_write;
                  pwdata     <= sel_wdata;
                  wait_cnt   <= '0;
               end
            end
            ACCESS: begin
               if (pready) begin
                  rsp_rdata <= pwrite ? 32'd0 : prdata;
                  rsp_err   <= 1'b0;
               end else begin
                  if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                  if (timeout_hit) begin
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // req_ready is gated by prst because the state sits in IDLE throughout reset.
   assign req_ready = (!prst && state == IDLE && sel_found) ? (ONE << sel_idx) : '0;
   assign rsp_valid = (state == RESP) ? (ONE << win_idx) : '0;
   assign psel      = (state == SETUP) || (state == ACCESS);
   assign penable   = (state == ACCESS);

endmodule
